// File: rtl/switch_conditioner.sv
// Five-bit switch front end: per-bit synchroniser, initial settle phase, then
// per-bit debounce with a registered change strobe for downstream capture.
module switch_conditioner #(
  parameter int unsigned N_SYNC          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] SW_IN,
  output logic       C1,
  output logic       C2,
  output logic       C3,
  output logic       C4,
  output logic       C5,
  output logic       valid,
  output logic       change
);

  localparam int unsigned NB    = 5;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                       state_q, state_d;
  logic [N_SYNC-1:0][NB-1:0]    sync_q, sync_d;
  logic [NB-1:0]                s_prev_q, s_prev_d;
  logic [CNT_W-1:0]             settle_q, settle_d;
  logic [NB-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NB-1:0]                c_q, c_d;
  logic                         valid_q, valid_d;
  logic                         change_q, change_d;
  logic [NB-1:0]                s;

  assign s = sync_q[N_SYNC-1];

  // Plain shift chain: nothing but flops between SW_IN and s
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = SW_IN;
    for (int i = 1; i < int'(N_SYNC); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    s_prev_d = s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      sync_q   <= '0;
      s_prev_q <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      c_q      <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      valid_q  <= valid_d;
      change_q <= change_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Whole vector must hold steady before the first level is accepted
        if (s == s_prev_q) begin
          if (settle_q == CNT_MAX) begin
            c_d      = s;
            settle_d = '0;
            valid_d  = 1'b1;
            state_d  = ST_RUN;
          end else begin
            settle_d = CNT_W'(settle_q + 1'b1);
          end
        end else begin
          settle_d = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < int'(NB); i++) begin
          if (s[i] == c_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            c_d[i]   = s[i];
            cnt_d[i] = '0;
            change_d = 1'b1;
          end else begin
            cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
          end
        end
      end
    endcase
  end

  assign C1     = c_q[4];
  assign C2     = c_q[3];
  assign C3     = c_q[2];
  assign C4     = c_q[1];
  assign C5     = c_q[0];
  assign valid  = valid_q;
  assign change = change_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner: settle, latency, glitch rejection,
// simultaneous updates, bounce, and asynchronous reset mid-count.
module tb_switch_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] sw_in;
  logic       c1, c2, c3, c4, c5;
  logic       valid, change;

  int n_checks;
  int n_fail;
  int change_cnt;
  int base;

  switch_conditioner #(.N_SYNC(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .SW_IN  (sw_in),
    .C1     (c1),
    .C2     (c2),
    .C3     (c3),
    .C4     (c4),
    .C5     (c5),
    .valid  (valid),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (change === 1'b1) change_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] cvec();
    return {c1, c2, c3, c4, c5};
  endfunction

  task automatic wait_valid(input int max_cycles);
    int k;
    k = 0;
    while (valid !== 1'b1 && k < max_cycles) begin
      tick(1);
      k++;
    end
    check("valid_wait", 32'(valid), 32'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    change_cnt = 0;
    rst        = 1'b1;
    sw_in      = 5'b10110;

    // Test 1: reset state and initial settle
    tick(3);
    check("rst_c",      32'(cvec()), 32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_change", 32'(change), 32'd0);
    rst = 1'b0;
    tick(16);
    check("init_not_early", 32'(valid), 32'd0);
    wait_valid(100);
    check("init_c",      32'(cvec()), 32'(5'b10110));
    check("init_change", 32'(change_cnt), 32'd0);
    tick(2);

    // Test 2: exact latency of C5 rising
    base  = change_cnt;
    sw_in = 5'b10111;
    tick(17);
    check("c5_before", 32'(c5), 32'd0);
    check("chg_before", 32'(change), 32'd0);
    tick(1);
    check("c5_edge", 32'(c5), 32'd1);
    check("chg_edge", 32'(change), 32'd1);
    tick(1);
    check("chg_after", 32'(change), 32'd0);
    check("c5_pulses", 32'(change_cnt - base), 32'd1);

    // Test 3: 15-cycle glitch on bit 2 is rejected and its count clears
    base = change_cnt;
    sw_in[2] = 1'b0;
    tick(15);
    sw_in[2] = 1'b1;
    tick(5);
    check("c3_glitch", 32'(c3), 32'd1);
    check("cnt2_clear", 32'(dut.cnt_q[2]), 32'd0);
    sw_in[2] = 1'b0;
    tick(15);
    sw_in[2] = 1'b1;
    tick(5);
    check("c3_glitch2", 32'(c3), 32'd1);
    check("glitch_pulses", 32'(change_cnt - base), 32'd0);

    // Test 4: bits 4 and 1 fall together
    base  = change_cnt;
    sw_in = 5'b00101;
    tick(17);
    check("c1c4_before", 32'({c1, c4}), 32'(2'b11));
    tick(1);
    check("c1c4_edge", 32'({c1, c4}), 32'(2'b00));
    check("c1c4_chg", 32'(change), 32'd1);
    tick(1);
    check("c1c4_pulses", 32'(change_cnt - base), 32'd1);
    check("c_after_t4", 32'(cvec()), 32'(5'b00101));

    // Test 5: bit 3 bouncing every 3 cycles, then held high
    base = change_cnt;
    for (int p = 0; p < 20; p++) begin
      sw_in[3] = (p % 2 == 0);
      tick(3);
    end
    check("c2_bounce", 32'(c2), 32'd0);
    sw_in[3] = 1'b1;
    tick(17);
    check("c2_before", 32'(c2), 32'd0);
    tick(1);
    check("c2_edge", 32'(c2), 32'd1);
    tick(1);
    check("bounce_pulses", 32'(change_cnt - base), 32'd1);

    // Test 6: async reset between edges while bit 0 is mid-count
    sw_in = 5'b00100;
    tick(12);
    check("cnt0_mid", 32'(dut.cnt_q[0]), 32'd10);
    check("pre_rst_c", 32'(cvec()), 32'(5'b01101));
    #2;
    rst = 1'b1;
    #1;
    check("async_c",      32'(cvec()), 32'd0);
    check("async_valid",  32'(valid),  32'd0);
    check("async_change", 32'(change), 32'd0);
    #2;
    rst  = 1'b0;
    base = change_cnt;
    tick(1);
    check("reinit_valid0", 32'(valid), 32'd0);
    wait_valid(100);
    check("reinit_c", 32'(cvec()), 32'(5'b00100));
    check("reinit_change", 32'(change_cnt - base), 32'd0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
